// File: rtl/isp_pkg.sv
// isp_pkg: shared constants for the ISP test-pattern transmitter.
//   PAT_*       pattern-select encodings for pattern_i
//   BAR_*       RGB888 colour-bar palette, left to right
//   state_t     transmitter FSM encoding
//   bar_color   bar index (0..7) to RGB888 colour
package isp_pkg;

    localparam int CW = 16;

    localparam logic [1:0] PAT_BARS   = 2'd0;
    localparam logic [1:0] PAT_GRAD   = 2'd1;
    localparam logic [1:0] PAT_CHECK  = 2'd2;
    localparam logic [1:0] PAT_SCROLL = 2'd3;

    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = BAR_WHITE;
            3'd1:    bar_color = BAR_YELLOW;
            3'd2:    bar_color = BAR_CYAN;
            3'd3:    bar_color = BAR_GREEN;
            3'd4:    bar_color = BAR_MAGENTA;
            3'd5:    bar_color = BAR_RED;
            3'd6:    bar_color = BAR_BLUE;
            default: bar_color = BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/isp_pattern_gen_timing.sv
// isp_pattern_gen_timing: h/v raster counters and region decode.
//   clk, rst       pixel clock, async active-high reset
//   adv            advance the raster by one cycle
//   x, y           active pixel / line coordinate (y truncated to 8 bits)
//   frame_start    counters at (0,0)
//   frame_end      counters at the last cycle of the frame
//   vsync_region   current line is a vsync line
//   active         current cycle is an active pixel
module isp_pattern_gen_timing
    import isp_pkg::*;
#(
    parameter int H_ACTIVE    = 1280,
    parameter int H_BLANK     = 370,
    parameter int V_ACTIVE    = 720,
    parameter int V_BLANK     = 30,
    parameter int VSYNC_LINES = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          adv,
    output logic [CW-1:0] x,
    output logic [7:0]    y,
    output logic          frame_start,
    output logic          frame_end,
    output logic          vsync_region,
    output logic          active
);

    localparam logic [CW-1:0] H_LAST = CW'(H_ACTIVE + H_BLANK - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_ACTIVE + V_BLANK - 1);
    localparam logic [CW-1:0] HB     = CW'(H_BLANK);
    localparam logic [CW-1:0] VB     = CW'(V_BLANK);
    localparam logic [CW-1:0] VS     = CW'(VSYNC_LINES);
    localparam logic [7:0]    VB8    = 8'(V_BLANK);

    logic [CW-1:0] h, v;
    logic          h_end, v_end;

    assign h_end = h == H_LAST;
    assign v_end = v == V_LAST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (adv) begin
            h <= h_end ? '0 : h + 1'b1;
            if (h_end)
                v <= v_end ? '0 : v + 1'b1;
        end
    end

    // Blanking precedes the active region on both axes, so the active
    // window always reaches the last counter value.
    assign frame_start  = h == '0 && v == '0;
    assign frame_end    = h_end && v_end;
    assign vsync_region = v < VS;
    assign active       = v >= VB && h >= HB;
    assign x            = h - HB;
    assign y            = v[7:0] - VB8;

endmodule

// File: rtl/isp_pattern_gen.sv
// isp_pattern_gen: ISP video-stream transmitter with four RGB888 test patterns.
//   clk, rst     pixel clock, async active-high reset
//   en_i         run request; a started frame always completes
//   pattern_i    0 bars, 1 gradient, 2 checkerboard, 3 scrolling ramp
//   vsync_o      frame sync (registered)
//   valid_o      active-pixel qualifier (registered)
//   data_o       pixel {R,G,B}, zero outside active pixels
//   frame_cnt_o  completed-frame count, wraps
//   busy_o       frame in progress
module isp_pattern_gen
    import isp_pkg::*;
#(
    parameter int H_ACTIVE    = 1280,
    parameter int H_BLANK     = 370,
    parameter int V_ACTIVE    = 720,
    parameter int V_BLANK     = 30,
    parameter int VSYNC_LINES = 5,
    parameter int DATA_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic [1:0]            pattern_i,
    output logic                  vsync_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [15:0]           frame_cnt_o,
    output logic                  busy_o
);

    generate
        if (DATA_WIDTH != 24) begin : g_bad_width
            $error("isp_pattern_gen: DATA_WIDTH must be 24");
        end
    endgenerate

    localparam logic [CW-1:0] BAR_W = CW'(H_ACTIVE / 8);

    state_t                state;
    logic [1:0]            pat_q;
    logic [CW-1:0]         x, bar_q;
    logic [7:0]            y, ramp;
    logic                  frame_start, frame_end, vsync_region, active, run;
    logic [DATA_WIDTH-1:0] pix;

    assign run = state != IDLE;

    isp_pattern_gen_timing #(
        .H_ACTIVE   (H_ACTIVE),
        .H_BLANK    (H_BLANK),
        .V_ACTIVE   (V_ACTIVE),
        .V_BLANK    (V_BLANK),
        .VSYNC_LINES(VSYNC_LINES)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .adv         (run),
        .x           (x),
        .y           (y),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .vsync_region(vsync_region),
        .active      (active)
    );

    // Bars past the eighth (H_ACTIVE not divisible by 8) stay black.
    always_comb begin
        bar_q = x / BAR_W;
        ramp  = x[7:0] + frame_cnt_o[7:0];
        pix   = pat_q == PAT_BARS  ? bar_color(|bar_q[CW-1:3] ? 3'd7 : bar_q[2:0]) :
                pat_q == PAT_GRAD  ? {3{x[7:0]}} :
                pat_q == PAT_CHECK ? {DATA_WIDTH{x[6] ^ y[6]}} :
                                     {ramp, y, 8'h00};
    end

    // Leaving RUN/FINISH only happens at frame end, where the counters wrap
    // to (0,0) by themselves, so IDLE always restarts from the frame origin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pat_q       <= PAT_BARS;
            vsync_o     <= 1'b0;
            valid_o     <= 1'b0;
            data_o      <= '0;
            frame_cnt_o <= '0;
            busy_o      <= 1'b0;
        end else begin
            state   <= en_i ? RUN : (run && !frame_end) ? FINISH : IDLE;
            if (run && frame_start)
                pat_q <= pattern_i;
            vsync_o <= run && vsync_region;
            valid_o <= run && active;
            data_o  <= (run && active) ? pix : '0;
            busy_o  <= run;
            if (run && frame_end)
                frame_cnt_o <= frame_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_isp_pattern_gen.sv
// tb_isp_pattern_gen: directed self-checking bench for isp_pattern_gen on a small raster.
module tb_isp_pattern_gen;

    localparam int HA = 16;
    localparam int HB = 4;
    localparam int VA = 4;
    localparam int VB = 3;
    localparam int VS = 1;
    localparam int HT = HA + HB;
    localparam int FT = HT * (VA + VB);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_i = 1'b0;
    logic [1:0]  pattern_i = 2'd0;
    logic        vsync_o, valid_o, busy_o;
    logic [23:0] data_o;
    logic [15:0] frame_cnt_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    isp_pattern_gen #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB),
        .VSYNC_LINES(VS), .DATA_WIDTH(24)
    ) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .pattern_i(pattern_i),
        .vsync_o(vsync_o), .valid_o(valid_o), .data_o(data_o),
        .frame_cnt_o(frame_cnt_o), .busy_o(busy_o)
    );

    function automatic logic [23:0] exp_pix(input int pat, input int x, input int y, input int fc);
        int idx;
        idx = x / (HA / 8);
        if (idx > 7) idx = 7;
        case (pat)
            0: case (idx)
                   0: return 24'hFFFFFF;
                   1: return 24'hFFFF00;
                   2: return 24'h00FFFF;
                   3: return 24'h00FF00;
                   4: return 24'hFF00FF;
                   5: return 24'hFF0000;
                   6: return 24'h0000FF;
                   default: return 24'h000000;
               endcase
            1: return {3{8'(x)}};
            2: return (((x >> 6) ^ (y >> 6)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
            default: return {8'(x + fc), 8'(y), 8'h00};
        endcase
    endfunction

    function automatic logic exp_vs(input int k);
        return (k / HT) < VS;
    endfunction

    function automatic logic exp_va(input int k);
        return (k / HT) >= VB && (k % HT) >= HB;
    endfunction

    function automatic logic [23:0] exp_data(input int pat, input int k, input int fc);
        return exp_va(k) ? exp_pix(pat, k % HT - HB, k / HT - VB, fc) : 24'h0;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        pattern_i = 2'd0;
        en_i = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        checks += 5;
        if (vsync_o !== 1'b0) begin failures++; $display("FAIL reset_vsync got=%b exp=0", vsync_o); end
        if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        if (data_o !== 24'h0) begin failures++; $display("FAIL reset_data got=%h exp=000000", data_o); end
        if (frame_cnt_o !== 16'h0) begin failures++; $display("FAIL reset_fcnt got=%0d exp=0", frame_cnt_o); end
        if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        rst = 1'b0;
        tick();
        checks += 2;
        if (vsync_o !== 1'b0) begin failures++; $display("FAIL start_vsync_early got=%b exp=0", vsync_o); end
        if (busy_o !== 1'b0) begin failures++; $display("FAIL start_busy_early got=%b exp=0", busy_o); end
        tick();
        checks += 2;
        if (vsync_o !== 1'b1) begin failures++; $display("FAIL start_vsync got=%b exp=1", vsync_o); end
        if (busy_o !== 1'b1) begin failures++; $display("FAIL start_busy got=%b exp=1", busy_o); end
    endtask

    task automatic test_bars;
        int vs, va, both;
        vs = 0; va = 0; both = 0;
        checks++;
        if (frame_cnt_o !== 16'd0) begin failures++; $display("FAIL bars_fcnt got=%0d exp=0", frame_cnt_o); end
        for (int k = 0; k < FT; k++) begin
            if (k == 70) pattern_i = 2'd1;
            checks += 3;
            if (vsync_o !== exp_vs(k)) begin failures++; $display("FAIL bars_vsync k=%0d got=%b exp=%b", k, vsync_o, exp_vs(k)); end
            if (valid_o !== exp_va(k)) begin failures++; $display("FAIL bars_valid k=%0d got=%b exp=%b", k, valid_o, exp_va(k)); end
            if (data_o !== exp_data(0, k, 0)) begin failures++; $display("FAIL bars_data k=%0d got=%h exp=%h", k, data_o, exp_data(0, k, 0)); end
            vs += int'(vsync_o);
            va += int'(valid_o);
            both += int'(vsync_o & valid_o);
            tick();
        end
        checks += 3;
        if (vs != VS * HT) begin failures++; $display("FAIL bars_vsync_count got=%0d exp=%0d", vs, VS * HT); end
        if (va != VA * HA) begin failures++; $display("FAIL bars_valid_count got=%0d exp=%0d", va, VA * HA); end
        if (both != 0) begin failures++; $display("FAIL bars_overlap got=%0d exp=0", both); end
    endtask

    task automatic test_pattern_switch;
        for (int f = 1; f <= 3; f++) begin
            checks++;
            if (frame_cnt_o !== 16'(f)) begin failures++; $display("FAIL switch_fcnt f=%0d got=%0d exp=%0d", f, frame_cnt_o, f); end
            for (int k = 0; k < FT; k++) begin
                if (k == 70 && f < 3) pattern_i = 2'(f + 1);
                checks += 3;
                if (vsync_o !== exp_vs(k)) begin failures++; $display("FAIL switch_vsync f=%0d k=%0d got=%b exp=%b", f, k, vsync_o, exp_vs(k)); end
                if (valid_o !== exp_va(k)) begin failures++; $display("FAIL switch_valid f=%0d k=%0d got=%b exp=%b", f, k, valid_o, exp_va(k)); end
                if (data_o !== exp_data(f, k, f)) begin failures++; $display("FAIL switch_data f=%0d k=%0d got=%h exp=%h", f, k, data_o, exp_data(f, k, f)); end
                tick();
            end
        end
    endtask

    task automatic test_en_drop;
        int hi;
        for (int f = 4; f <= 5; f++) begin
            for (int k = 0; k < FT; k++) begin
                if (f == 4 && k == 30) en_i = 1'b0;
                if (f == 4 && k == 100) en_i = 1'b1;
                if (f == 5 && k == 30) en_i = 1'b0;
                checks += 4;
                if (vsync_o !== exp_vs(k)) begin failures++; $display("FAIL drop_vsync f=%0d k=%0d got=%b exp=%b", f, k, vsync_o, exp_vs(k)); end
                if (valid_o !== exp_va(k)) begin failures++; $display("FAIL drop_valid f=%0d k=%0d got=%b exp=%b", f, k, valid_o, exp_va(k)); end
                if (data_o !== exp_data(3, k, f)) begin failures++; $display("FAIL drop_data f=%0d k=%0d got=%h exp=%h", f, k, data_o, exp_data(3, k, f)); end
                if (busy_o !== 1'b1) begin failures++; $display("FAIL drop_busy f=%0d k=%0d got=%b exp=1", f, k, busy_o); end
                tick();
            end
        end
        checks += 3;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL drop_busy_fall got=%b exp=0", busy_o); end
        if (vsync_o !== 1'b0) begin failures++; $display("FAIL drop_vsync_after got=%b exp=0", vsync_o); end
        if (frame_cnt_o !== 16'd6) begin failures++; $display("FAIL drop_fcnt got=%0d exp=6", frame_cnt_o); end
        hi = 0;
        for (int k = 0; k < 150; k++) begin
            hi += int'(vsync_o | valid_o | busy_o);
            tick();
        end
        checks++;
        if (hi != 0) begin failures++; $display("FAIL idle_activity got=%0d exp=0", hi); end
    endtask

    task automatic test_rst_mid;
        pattern_i = 2'd0;
        en_i = 1'b1;
        tick();
        tick();
        repeat (70) tick();
        checks += 2;
        if (valid_o !== 1'b1) begin failures++; $display("FAIL mid_valid got=%b exp=1", valid_o); end
        if (data_o !== 24'h00FF00) begin failures++; $display("FAIL mid_data got=%h exp=00ff00", data_o); end
        rst = 1'b1;
        #1;
        checks += 5;
        if (vsync_o !== 1'b0) begin failures++; $display("FAIL rst_vsync got=%b exp=0", vsync_o); end
        if (valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", valid_o); end
        if (data_o !== 24'h0) begin failures++; $display("FAIL rst_data got=%h exp=000000", data_o); end
        if (frame_cnt_o !== 16'h0) begin failures++; $display("FAIL rst_fcnt got=%0d exp=0", frame_cnt_o); end
        if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (vsync_o !== 1'b0) begin failures++; $display("FAIL restart_vsync_early got=%b exp=0", vsync_o); end
        tick();
        for (int k = 0; k < FT; k++) begin
            checks += 3;
            if (vsync_o !== exp_vs(k)) begin failures++; $display("FAIL restart_vsync k=%0d got=%b exp=%b", k, vsync_o, exp_vs(k)); end
            if (valid_o !== exp_va(k)) begin failures++; $display("FAIL restart_valid k=%0d got=%b exp=%b", k, valid_o, exp_va(k)); end
            if (data_o !== exp_data(0, k, 0)) begin failures++; $display("FAIL restart_data k=%0d got=%h exp=%h", k, data_o, exp_data(0, k, 0)); end
            tick();
        end
        checks++;
        if (frame_cnt_o !== 16'd1) begin failures++; $display("FAIL restart_fcnt got=%0d exp=1", frame_cnt_o); end
    endtask

    initial begin
        test_reset();
        test_bars();
        test_pattern_switch();
        test_en_drop();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/isp_pattern_gen.md
# isp_pattern_gen

Synthesizable ISP video-stream transmitter. It produces the `vsync` / `valid` / `data` stream that the ISP pipeline stages and the delay stages consume. The block sits at the head of the ISP chain in place of the camera path. It is used for bring-up of the 720p30 HDMI output and as the stimulus source for downstream ISP blocks. It generates frame and line timing from counters and one of four RGB888 test patterns.

## Interface

Parameters:
- `H_ACTIVE`, default 1280: active pixels per line.
- `H_BLANK`, default 370: blank cycles per line. Line length is `H_ACTIVE+H_BLANK` = 1650.
- `V_ACTIVE`, default 720: active lines per frame.
- `V_BLANK`, default 30: blank lines per frame. Must be ≥ `VSYNC_LINES`.
- `VSYNC_LINES`, default 5: lines with `vsync_o` high at frame start.
- `DATA_WIDTH`, default 24: RGB888 `{R[23:16],G[15:8],B[7:0]}`. 24 is the only legal value; any other value is an elaboration error.

Ports:
- `clk`  in  1  pixel clock. Single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `en_i`  in  1  run request.
- `pattern_i`  in  2  pattern select. 0 colour bars, 1 gradient, 2 checkerboard, 3 scrolling ramp.
- `vsync_o`  out  1  frame sync.
- `valid_o`  out  1  active-pixel qualifier.
- `data_o`  out  `DATA_WIDTH`  pixel.
- `frame_cnt_o`  out  16  completed-frame count. Wraps at 0xFFFF→0.
- `busy_o`  out  1  high while a frame is in progress.

## Operation

- Counters:
  - `h` runs 0..`H_ACTIVE+H_BLANK-1`.
  - `v` runs 0..`V_ACTIVE+V_BLANK-1`.
  - `h` wraps and increments `v`. `v` wraps at the end of the frame.
- Frame layout:
  - Lines `v` < `VSYNC_LINES` → vsync region.
  - Lines `V_BLANK` ≤ `v` < `V_BLANK+V_ACTIVE` → active lines. Active-line coordinate `y = v-V_BLANK`.
  - In an active line, cycles `H_BLANK` ≤ `h` < `H_BLANK+H_ACTIVE` → active pixels. Pixel coordinate `x = h-H_BLANK`.
- FSM states `IDLE`, `RUN`, `FINISH`:
  - `IDLE`, `en_i`=1 → `RUN`. Counters start at (0,0).
  - `RUN`, `en_i`=0 → `FINISH`.
  - `FINISH`, `en_i`=1 → `RUN`. No gap; the frame continues.
  - `RUN` or `FINISH` at the last cycle of a frame:
    - `FINISH` → `IDLE`, counters reset to 0.
    - `RUN` → wrap and continue with the next frame.
  - A frame is never truncated by `en_i`.
- `pattern_i` is sampled into a register at `h`=0, `v`=0. A mid-frame change takes effect on the next frame.
- Patterns, evaluated at (x, y):
  - Colour bars: bar width `H_ACTIVE/8`. Index = x/width, clamped to 7. Order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - Gradient: R=G=B=x[7:0].
  - Checkerboard: FFFFFF if x[6]^y[6], else 000000.
  - Scrolling ramp: R=(x+frame_cnt)[7:0], G=y[7:0], B=0.
- `data_o` is 0 whenever `valid_o`=0.
- `frame_cnt_o` increments on the last cycle of each completed frame.
- `busy_o` = state ≠ `IDLE`.

## Timing

- Reset (asynchronous assert, synchronous release): state `IDLE`, counters 0, and every output 0: `vsync_o`, `valid_o`, `data_o`, `frame_cnt_o`, `busy_o`.
- All outputs are registered.
- Output latency is 1 cycle from the counter state. `en_i` sampled high in `IDLE` at edge N gives `vsync_o`=1 after edge N+1.
- `vsync_o` is high for exactly `VSYNC_LINES*(H_ACTIVE+H_BLANK)` consecutive cycles per frame.
- `valid_o` is high for `H_ACTIVE` consecutive cycles per active line, with `V_ACTIVE` such runs per frame.
- `vsync_o` and `valid_o` are never high simultaneously.
- Frame period is `(H_ACTIVE+H_BLANK)*(V_ACTIVE+V_BLANK)` cycles. That is 1,237,500 at defaults, i.e. 30 Hz at 37.125 MHz.
- Reset mid-frame: outputs are 0 immediately. After release, the block waits in `IDLE` for `en_i`.

## Structure

- Shared package `isp_pkg` holds:
  - pattern-select constants `PAT_BARS`, `PAT_GRAD`, `PAT_CHECK`, `PAT_SCROLL`;
  - the eight RGB888 bar colour constants;
  - FSM state encodings.
- Sub-module `isp_pattern_gen_timing` contains the h/v counters, frame-end strobe and region decode (vsync region, active, x, y). The top level holds the FSM, the pattern register, pixel generation and output registers.

## Test plan

- Apply reset with `en_i`=1 → all outputs 0 during reset. After release, `vsync_o` rises exactly 2 cycles later (1 cycle to leave `IDLE`, 1 cycle of output register).
- Default parameters, pattern 0, run 2 frames:
  - count 921,600 `valid_o` cycles per frame;
  - count 8,250 `vsync_o` cycles per frame;
  - frame period 1,237,500 cycles;
  - `frame_cnt_o` reads 2;
  - first active line: x=0 → FFFFFF, x=160 → FFFF00, x=1279 → 000000.
- Small parameters (H_ACTIVE=16, H_BLANK=4, V_ACTIVE=4, V_BLANK=3, VSYNC_LINES=1), pattern 1 → each active line shows data 0x000000..0x0F0F0F in order.
- Switch pattern 1→2 mid-frame → the current frame stays gradient; the next frame is checkerboard.
- Drop `en_i` mid-frame → the frame completes, `busy_o` falls 1 cycle after the last frame cycle, no further `vsync_o`. Re-raise `en_i` during `FINISH` → no gap between frames.
- Assert `rst` mid-active-line → outputs 0 the same cycle, `frame_cnt_o`=0. Restart with `en_i` → the frame begins from `v`=0.
